// File: rtl/pipelined_adder.sv
// Pipelined block adder: each stage adds one BLK_SIZE slice with operands skewed forward,
// followed by a result register that applies subtract/saturation flags and drives the outputs.
module pipelined_adder #(
   parameter int WIDTH    = 32,
   parameter int BLK_SIZE = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   input  logic             sub,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);
   localparam int NUM_STAGES = WIDTH / BLK_SIZE;
   localparam int LAST_LO    = (NUM_STAGES - 1) * BLK_SIZE;

   if (BLK_SIZE < 1 || WIDTH % BLK_SIZE != 0) begin : g_bad_params
      $error("pipelined_adder: WIDTH must be a nonzero multiple of BLK_SIZE");
   end

   // Valid/ready: a side transfers only on a clk edge where both valid and ready are high.
   // The whole pipe, bubbles included, advances in lockstep unless a result is held at the output.
   logic advance;
   assign advance  = !(out_valid && !out_ready);
   assign in_ready = advance;

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stg
      localparam int LO = k * BLK_SIZE;
      logic              v_q;
      logic              sat_q;
      logic              c_q;   // carry into slice k
      logic [WIDTH-1:0]  x_q;   // finished sum bits below LO, operand A from LO upward
      logic [WIDTH-1:LO] y_q;   // effective operand B (already inverted for sub) from LO upward

      if (k == 0) begin : g_load
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               v_q   <= 1'b0;
               sat_q <= 1'b0;
               c_q   <= 1'b0;
               x_q   <= '0;
               y_q   <= '0;
            end else if (advance) begin
               v_q   <= in_valid;
               sat_q <= sat;
               c_q   <= sub | carry_in;
               x_q   <= a;
               y_q   <= sub ? ~b : b;
            end
         end
      end else begin : g_load
         localparam int PL = LO - BLK_SIZE;
         logic [BLK_SIZE:0] add;
         logic [WIDTH-1:0]  x_nxt;

         always_comb begin
            add = {1'b0, g_stg[k-1].x_q[PL +: BLK_SIZE]}
                + {1'b0, g_stg[k-1].y_q[PL +: BLK_SIZE]}
                + {{BLK_SIZE{1'b0}}, g_stg[k-1].c_q};
            x_nxt = g_stg[k-1].x_q;
            x_nxt[PL +: BLK_SIZE] = add[BLK_SIZE-1:0];
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               v_q   <= 1'b0;
               sat_q <= 1'b0;
               c_q   <= 1'b0;
               x_q   <= '0;
               y_q   <= '0;
            end else if (advance) begin
               v_q   <= g_stg[k-1].v_q;
               sat_q <= g_stg[k-1].sat_q;
               c_q   <= add[BLK_SIZE];
               x_q   <= x_nxt;
               y_q   <= g_stg[k-1].y_q[WIDTH-1:LO];
            end
         end
      end
   end

   logic [BLK_SIZE:0] last_add;
   logic [WIDTH-1:0]  raw_sum;
   logic [WIDTH-1:0]  res_sum;
   logic              msb_cin;
   logic              ovf;

   always_comb begin
      last_add = {1'b0, g_stg[NUM_STAGES-1].x_q[LAST_LO +: BLK_SIZE]}
               + {1'b0, g_stg[NUM_STAGES-1].y_q[LAST_LO +: BLK_SIZE]}
               + {{BLK_SIZE{1'b0}}, g_stg[NUM_STAGES-1].c_q};
      raw_sum = g_stg[NUM_STAGES-1].x_q;
      raw_sum[LAST_LO +: BLK_SIZE] = last_add[BLK_SIZE-1:0];
      // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
      msb_cin = g_stg[NUM_STAGES-1].x_q[WIDTH-1] ^ g_stg[NUM_STAGES-1].y_q[WIDTH-1] ^ raw_sum[WIDTH-1];
      ovf     = msb_cin ^ last_add[BLK_SIZE];
      res_sum = raw_sum;
      if (g_stg[NUM_STAGES-1].sat_q && ovf) begin
         res_sum = g_stg[NUM_STAGES-1].y_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                    : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end

   // Result fields only load with a valid result, so they keep the last one through bubbles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else if (advance) begin
         out_valid <= g_stg[NUM_STAGES-1].v_q;
         if (g_stg[NUM_STAGES-1].v_q) begin
            sum       <= res_sum;
            carry_out <= last_add[BLK_SIZE];
            overflow  <= ovf;
         end
      end
   end

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder (WIDTH=16, BLK_SIZE=4): directed corner cases, stall, reset flush
// and a long randomized valid/ready run checked against an integer-arithmetic reference.
module tb_pipelined_adder;
   localparam int W = 16;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         carry_in;
   logic         sub;
   logic         sat;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         carry_out;
   logic         overflow;

   pipelined_adder #(.WIDTH(W), .BLK_SIZE(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
      .sub       (sub),
      .sat       (sat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int           n_checks = 0;
   int           n_fail   = 0;
   int           n_out    = 0;
   logic [W+1:0] exp_q[$];       // {overflow, carry_out, sum}
   logic         hold_chk = 1'b0;
   logic [W+1:0] held;
   logic         last_acc;
   logic         last_in_ready;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain signed/unsigned integer sums of the operands.
   function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mcin, input logic msub, input logic msat);
      logic [W-1:0] be;
      logic [W-1:0] res;
      int           c0;
      int           s_val;
      int           u_val;
      logic         ov;
      logic         co;
      be    = msub ? ~mb : mb;
      c0    = msub ? 1 : int'(mcin);
      s_val = int'($signed(ma)) + int'($signed(be)) + c0;
      u_val = int'(ma) + int'(be) + c0;
      ov    = (s_val > 32767) || (s_val < -32768);
      co    = (u_val > 65535);
      res   = u_val[W-1:0];
      if (msat && ov) res = (s_val > 0) ? 16'h7FFF : 16'h8000;
      return {ov, co, res};
   endfunction

   // One clock: sample just after inputs settle, score transfers, then cross the edge.
   task automatic cycle();
      logic         del;
      logic [W+1:0] exp;
      #1;
      if (hold_chk) begin
         check("stall_valid_held", out_valid, 1'b1);
         check("stall_outputs_held", {overflow, carry_out, sum}, held);
      end
      check("in_ready_rule", in_ready, !(out_valid && !out_ready));
      last_in_ready = in_ready;
      last_acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (del) begin
         if (exp_q.size() == 0) begin
            check("spurious_out_valid", out_valid, 1'b0);
         end else begin
            exp = exp_q.pop_front();
            check("result", {overflow, carry_out, sum}, exp);
            n_out++;
         end
      end
      hold_chk = out_valid && !out_ready;
      held = {overflow, carry_out, sum};
      if (last_acc) exp_q.push_back(model(a, b, carry_in, sub, sat));
      @(posedge clk);
      #1;
   endtask

   // driver: single transaction into an empty pipe, then latency and value checks
   task automatic directed(input string tag, input logic [W-1:0] da, input logic [W-1:0] db,
                           input logic dcin, input logic dsub, input logic dsat,
                           input logic [W-1:0] esum, input logic ecout, input logic eovf);
      int n;
      a = da; b = db; carry_in = dcin; sub = dsub; sat = dsat;
      in_valid = 1'b1; out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); carry_in = ~dcin; sub = ~dsub; sat = ~dsat;
      n = 0;
      while (!out_valid && n < 20) begin
         cycle();
         n++;
      end
      check({tag, "_latency"}, n, 4);
      check({tag, "_sum"}, sum, esum);
      check({tag, "_carry_out"}, carry_out, ecout);
      check({tag, "_overflow"}, overflow, eovf);
      cycle();
   endtask

   logic [W-1:0] ta[8];
   logic [W-1:0] tbv[8];

   initial begin
      int idx, stall, guard, n0, acc_cnt, n;
      logic stall_done;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0; sat = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_sum", sum, 16'h0000);
      check("reset_carry_out", carry_out, 1'b0);
      check("reset_overflow", overflow, 1'b0);
      rst = 1'b0;
      check("post_reset_in_ready", in_ready, 1'b1);

      directed("ovf_pos",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      directed("ovf_pos_sat", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
      directed("ripple",      16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      directed("sub_ovf_sat", 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1);
      directed("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
      directed("sub_noborrow",16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0);
      directed("sub_borrow",  16'h0003, 16'h0005, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      directed("neg_ovf_sat", 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1);
      directed("all_ones_cin",16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);

      // eight back-to-back, output stalled three cycles at first result
      for (int k = 0; k < 8; k++) begin
         ta[k] = 16'($urandom);
         tbv[k] = 16'($urandom);
      end
      idx = 0; stall = 0; stall_done = 1'b0; guard = 0; n0 = n_out;
      carry_in = 1'b0; sub = 1'b0; sat = 1'b0;
      while ((idx < 8 || exp_q.size() != 0) && guard < 60) begin
         in_valid = (idx < 8);
         if (idx < 8) begin
            a = ta[idx];
            b = tbv[idx];
         end
         if (out_valid && !stall_done) begin
            stall = 3;
            stall_done = 1'b1;
         end
         out_ready = (stall == 0);
         cycle();
         if (stall > 0) begin
            check("b2b_in_ready_stalled", last_in_ready, 1'b0);
            stall--;
         end
         if (last_acc) idx++;
         guard++;
      end
      check("b2b_delivered", n_out - n0, 8);
      check("b2b_queue_empty", exp_q.size(), 0);
      in_valid = 1'b0;
      out_ready = 1'b1;

      // reset with three transactions in flight
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
         cycle();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("async_rst_out_valid", out_valid, 1'b0);
      check("async_rst_sum", sum, 16'h0000);
      check("async_rst_flags", {carry_out, overflow}, 2'b00);
      exp_q.delete();
      hold_chk = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_release_in_ready", in_ready, 1'b1);
      for (int k = 0; k < 8; k++) begin
         check("rst_flush_no_valid", out_valid, 1'b0);
         cycle();
      end
      directed("after_rst", 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0, 16'h5556, 1'b0, 1'b0);

      // randomized valid/ready traffic
      acc_cnt = 0; guard = 0;
      while (acc_cnt < 10000 && guard < 60000) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         a = 16'($urandom); b = 16'($urandom);
         carry_in = 1'($urandom); sub = 1'($urandom); sat = 1'($urandom);
         cycle();
         if (last_acc) acc_cnt++;
         guard++;
      end
      check("rand_accepted", acc_cnt, 10000);
      in_valid = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         cycle();
         n++;
      end
      check("rand_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
